hamming_deserializer: RTL and testbench
=======================================

HAMMING_DESERIALIZER -- requirements
Module: hamming_deserializer

Interface
REQ-001 The block SHALL have parameter P, default 3, meaning Hamming parity-bit count; codeword length N = 2**P - 1 (7 at default).
REQ-002 The block SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-003 The block SHALL have port rst_bar, input, 1, meaning reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port bit_en, input, 1, meaning the bit-sample strobe; rx_bit is sampled only on edges where bit_en=1.
REQ-005 The block SHALL have port rx_bit, input, 1, meaning the serial line; idle level is 1.
REQ-006 The block SHALL have port rx_msg, output, N, meaning the received codeword, which feeds the downstream Hamming decoder.
REQ-007 The block SHALL have port msg_valid, output, 1, meaning rx_msg holds an unconsumed codeword.
REQ-008 The block SHALL have port msg_ready, input, 1, meaning the downstream stage accepts rx_msg.
REQ-009 The block SHALL have port frame_err, output, 1, meaning a one-cycle pulse when a stop bit is 0.
REQ-010 The block SHALL have port overrun, output, 1, meaning a one-cycle pulse when a completed frame is dropped.
REQ-011 The block SHALL have port frame_count, output, 16, meaning the accepted-frame count (see Configuration).

Function
REQ-012 The frame format SHALL be: start bit 0, then N codeword bits LSB-first (rx_msg[0] first), then stop bit 1.
REQ-013 The FSM SHALL have exactly the states IDLE, DATA, STOP and WAIT_IDLE; state changes occur only on bit_en edges, except for reset.
REQ-014 In IDLE, a sample of rx_bit=0 SHALL move the FSM to DATA with the bit counter at 0; a sample of 1 SHALL keep it in IDLE.
REQ-015 In DATA, each sample SHALL be shifted into a shift register and the counter incremented; after the N-th sample the FSM SHALL move to STOP.
REQ-016 The bit counter SHALL be $clog2(N+1) bits wide and SHALL never exceed N.
REQ-017 In STOP, a sample of 1 SHALL complete the frame and return the FSM to IDLE.
REQ-018 In STOP, a sample of 0 SHALL pulse frame_err for one cycle, discard the shift register and move the FSM to WAIT_IDLE.
REQ-019 WAIT_IDLE SHALL return to IDLE on the first sample of 1.
REQ-020 On completion with msg_valid=0, the block SHALL load rx_msg and set msg_valid at the same edge; latency is 1 cycle from the stop-bit sample edge to visibility.
REQ-021 A handshake SHALL occur on an edge with msg_valid=1 and msg_ready=1; msg_valid SHALL then clear unless a new frame completes on that same edge, in which case the new frame is loaded and msg_valid stays 1.
REQ-022 On completion with msg_valid=1 and msg_ready=0, the new frame SHALL be dropped, overrun SHALL pulse for one cycle, and rx_msg SHALL be unchanged.
REQ-023 While msg_valid=1, rx_msg SHALL be stable.

Reset
REQ-024 When rst_bar=0, the block SHALL immediately force: state IDLE; counter 0; shift register 0; rx_msg 0; msg_valid, frame_err and overrun 0; frame_count 0.
REQ-025 A reset asserted mid-frame SHALL abandon the partial frame without any pulse.

Configuration
REQ-026 With HAMMING_STATS_EN defined, frame_count SHALL increment on every load per REQ-020/REQ-021 and wrap from 16'hFFFF to 0.
REQ-027 Without HAMMING_STATS_EN, frame_count SHALL be tied to 0 and no counter logic SHALL be synthesized.
REQ-028 All other behaviour SHALL be identical with and without HAMMING_STATS_EN.

Structure
REQ-029 The package hamming_pkg SHALL hold the default P, a codeword-length function N(P), and the FSM state enum typedef.
REQ-030 The frame counter SHALL be the sub-module hamming_stat_counter (width parameter, enable, wrap), instantiated only under HAMMING_STATS_EN.

Verification
REQ-031 Reset: the bench SHALL drive rst_bar=0 mid-idle and check all outputs are 0 and the FSM is in IDLE.
REQ-032 Normal frame: the bench SHALL send codeword 7'b1010101 with stop bit 1 and check rx_msg=7'b1010101 and msg_valid=1 one cycle after the stop sample, held until msg_ready; frame_count=1 if enabled.
REQ-033 Framing error: the bench SHALL send 7'b0011001 with stop bit 0 and check a frame_err pulse, msg_valid=0, and no capture until the line returns to 1 and a new start bit arrives.
REQ-034 Overrun: the bench SHALL hold msg_ready=0 and send 7'b1111111 then 7'b0000001, and check an overrun pulse with rx_msg still 7'b1111111.
REQ-035 Simultaneous events: the bench SHALL assert msg_ready on the same edge a second frame (7'b0101010) completes, and check no overrun, rx_msg=7'b0101010 and msg_valid staying 1.
REQ-036 Reset mid-frame: the bench SHALL assert rst_bar=0 after 3 data bits, then send a full 7'b1100110 frame, and check rx_msg=7'b1100110 with no frame_err.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming codeword deserializer: default parity count,
// codeword length helper and receive FSM state type.
package hamming_pkg;

  localparam int unsigned DefaultP = 3;

  function automatic int unsigned codeword_len(input int unsigned p);
    return (32'd1 << p) - 32'd1;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StStop,
    StWaitIdle
  } state_e;

endpackage

// File: rtl/hamming_stat_counter.sv
// Free-running frame counter that advances on each enable and wraps at all-ones.
module hamming_stat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_bar,
  input  logic             en,
  output logic [Width-1:0] count
);

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      count <= '0;
    end else if (en) begin
      count <= count + Width'(1);
    end
  end

endmodule

// File: rtl/hamming_deserializer.sv
// Serial-to-parallel receiver for Hamming codewords (start, N bits LSB-first, stop).
// Optional frame statistics counter enabled by defining HAMMING_STATS_EN.
module hamming_deserializer
  import hamming_pkg::*;
#(
  parameter  int unsigned P = DefaultP,
  localparam int unsigned N = codeword_len(P)
) (
  input  logic         clk,
  input  logic         rst_bar,
  input  logic         bit_en,
  input  logic         rx_bit,
  output logic [N-1:0] rx_msg,
  output logic         msg_valid,
  input  logic         msg_ready,
  output logic         frame_err,
  output logic         overrun,
  output logic [15:0]  frame_count
);

  localparam int unsigned CntW = $clog2(N + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [N-1:0]    shift_q;
  logic            last_bit;
  logic            start_en, shift_en, complete, stop_err;
  logic            load;

  assign last_bit = (cnt_q == CntW'(N - 1));

  // State register
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; transitions only on sample strobes
  always_comb begin
    state_d = state_q;
    if (bit_en) begin
      case (state_q)
        StIdle:     if (!rx_bit) state_d = StData;
        StData:     if (last_bit) state_d = StStop;
        StStop:     state_d = rx_bit ? StIdle : StWaitIdle;
        StWaitIdle: if (rx_bit) state_d = StIdle;
        default:    state_d = StIdle;
      endcase
    end
  end

  // FSM decode outputs
  always_comb begin
    start_en = 1'b0;
    shift_en = 1'b0;
    complete = 1'b0;
    stop_err = 1'b0;
    if (bit_en) begin
      case (state_q)
        StIdle: start_en = !rx_bit;
        StData: shift_en = 1'b1;
        StStop: begin
          complete = rx_bit;
          stop_err = !rx_bit;
        end
        default: ;
      endcase
    end
  end

  // A completed frame is taken if the output slot is free or being drained this edge
  assign load = complete && (!msg_valid || msg_ready);

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      cnt_q     <= '0;
      shift_q   <= '0;
      rx_msg    <= '0;
      msg_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_err;
      overrun   <= complete && msg_valid && !msg_ready;

      if (start_en) begin
        cnt_q <= '0;
      end else if (shift_en) begin
        cnt_q <= cnt_q + CntW'(1);
      end

      // First received bit ends up in bit 0 after N right shifts
      if (shift_en) begin
        shift_q <= {rx_bit, shift_q[N-1:1]};
      end else if (stop_err) begin
        shift_q <= '0;
      end

      if (load) begin
        rx_msg    <= shift_q;
        msg_valid <= 1'b1;
      end else if (msg_ready) begin
        msg_valid <= 1'b0;
      end
    end
  end

`ifdef HAMMING_STATS_EN
  hamming_stat_counter #(
    .Width(16)
  ) u_stat_counter (
    .clk    (clk),
    .rst_bar(rst_bar),
    .en     (load),
    .count  (frame_count)
  );
`else
  assign frame_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hamming_deserializer.sv
// Directed table-driven bench for hamming_deserializer plus hand-written corner sequences.
module tb_hamming_deserializer;
  import hamming_pkg::*;

  localparam int unsigned N = 7;
`ifdef HAMMING_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_bar = 1'b0;
  logic         bit_en = 1'b0;
  logic         rx_bit = 1'b1;
  logic         msg_ready = 1'b0;
  logic [N-1:0] rx_msg;
  logic         msg_valid, frame_err, overrun;
  logic [15:0]  frame_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hamming_deserializer #(
    .P(3)
  ) dut (
    .clk        (clk),
    .rst_bar    (rst_bar),
    .bit_en     (bit_en),
    .rx_bit     (rx_bit),
    .rx_msg     (rx_msg),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .frame_count(frame_count)
  );

  typedef struct {
    logic         pre_consume;
    logic [N-1:0] cw;
    logic         stop;
    logic         rdy_on_stop;
    logic [N-1:0] exp_msg;
    logic         exp_valid;
    logic         exp_ferr;
    logic         exp_ovr;
    int           exp_cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cnt_exp(input int c);
    return Stats ? 16'(c) : 16'h0000;
  endfunction

  task automatic send_bit(input logic b, input logic rdy);
    @(negedge clk);
    rx_bit    = b;
    bit_en    = 1'b1;
    msg_ready = rdy;
    @(negedge clk);
    bit_en    = 1'b0;
    msg_ready = 1'b0;
    rx_bit    = 1'b1;
  endtask

  task automatic send_frame(input logic [N-1:0] cw, input logic stop, input logic rdy_on_stop);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < N; i++) send_bit(cw[i], 1'b0);
    send_bit(stop, rdy_on_stop);
  endtask

  task automatic handshake();
    @(negedge clk);
    msg_ready = 1'b1;
    @(negedge clk);
    msg_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rx_msg"}, 32'(rx_msg), 32'h0);
    check({tag, " msg_valid"}, 32'(msg_valid), 32'h0);
    check({tag, " frame_err"}, 32'(frame_err), 32'h0);
    check({tag, " overrun"}, 32'(overrun), 32'h0);
    check({tag, " frame_count"}, 32'(frame_count), 32'h0);
    check({tag, " state"}, 32'(dut.state_q), 32'(StIdle));
  endtask

  initial begin
    vecs[0] = '{1'b0, 7'b1010101, 1'b1, 1'b0, 7'b1010101, 1'b1, 1'b0, 1'b0, 1};
    vecs[1] = '{1'b1, 7'b0011001, 1'b0, 1'b0, 7'b1010101, 1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{1'b0, 7'b1111111, 1'b1, 1'b0, 7'b1111111, 1'b1, 1'b0, 1'b0, 2};
    vecs[3] = '{1'b0, 7'b0000001, 1'b1, 1'b0, 7'b1111111, 1'b1, 1'b0, 1'b1, 2};
    vecs[4] = '{1'b0, 7'b0101010, 1'b1, 1'b1, 7'b0101010, 1'b1, 1'b0, 1'b0, 3};

    // Power-on reset, then an asynchronous reset pulse in the middle of idle
    repeat (3) @(negedge clk);
    check_all_zero("por");
    rst_bar = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    @(negedge clk);
    #2 rst_bar = 1'b0;
    #1 check_all_zero("idle rst");
    @(negedge clk);
    rst_bar = 1'b1;

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].pre_consume) handshake();
      send_frame(vecs[i].cw, vecs[i].stop, vecs[i].rdy_on_stop);
      check($sformatf("v%0d rx_msg", i), 32'(rx_msg), 32'(vecs[i].exp_msg));
      check($sformatf("v%0d msg_valid", i), 32'(msg_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
      check($sformatf("v%0d overrun", i), 32'(overrun), 32'(vecs[i].exp_ovr));
      check($sformatf("v%0d frame_count", i), 32'(frame_count),
            32'(cnt_exp(vecs[i].exp_cnt)));
      @(negedge clk);
      check($sformatf("v%0d frame_err end", i), 32'(frame_err), 32'h0);
      check($sformatf("v%0d overrun end", i), 32'(overrun), 32'h0);
      check($sformatf("v%0d rx_msg hold", i), 32'(rx_msg), 32'(vecs[i].exp_msg));
    end

    // Output held stable until consumed
    repeat (6) @(negedge clk);
    check("hold rx_msg", 32'(rx_msg), 32'(7'b0101010));
    check("hold msg_valid", 32'(msg_valid), 32'h1);
    handshake();
    check("drain msg_valid", 32'(msg_valid), 32'h0);

    // Framing error: zeros on the line must not restart reception
    send_frame(7'b0011001, 1'b0, 1'b0);
    check("ferr pulse", 32'(frame_err), 32'h1);
    check("ferr msg_valid", 32'(msg_valid), 32'h0);
    check("ferr state", 32'(dut.state_q), 32'(StWaitIdle));
    repeat (3) send_bit(1'b0, 1'b0);
    check("ferr wait state", 32'(dut.state_q), 32'(StWaitIdle));
    check("ferr wait valid", 32'(msg_valid), 32'h0);
    check("ferr wait pulse", 32'(frame_err), 32'h0);
    send_bit(1'b1, 1'b0);
    check("ferr back idle", 32'(dut.state_q), 32'(StIdle));
    send_frame(7'b0110011, 1'b1, 1'b0);
    check("recover rx_msg", 32'(rx_msg), 32'(7'b0110011));
    check("recover valid", 32'(msg_valid), 32'h1);
    check("recover count", 32'(frame_count), 32'(cnt_exp(4)));
    handshake();

    // Reset after three data bits abandons the frame silently
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    @(negedge clk);
    #2 rst_bar = 1'b0;
    #1 check_all_zero("mid rst");
    check("mid rst cnt", 32'(dut.cnt_q), 32'h0);
    @(negedge clk);
    rst_bar = 1'b1;
    check("mid rst no ferr", 32'(frame_err), 32'h0);
    send_frame(7'b1100110, 1'b1, 1'b0);
    check("post rst rx_msg", 32'(rx_msg), 32'(7'b1100110));
    check("post rst valid", 32'(msg_valid), 32'h1);
    check("post rst ferr", 32'(frame_err), 32'h0);
    check("post rst count", 32'(frame_count), 32'(cnt_exp(1)));
    @(negedge clk);
    check("post rst ferr end", 32'(frame_err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
